// File: rtl/id_pipe.sv
`default_nettype none
// ============================================================================
// Module   : id_pipe -- MIPS-subset decode stage: operand fetch, hazard stall, registered output.
// Options  : define ID_PIPE_FWD_EN to forward EX/MEM results instead of stalling.  Revision: 1.0
// ============================================================================
module id_pipe #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid_i,
  output logic              if_ready_o,
  input  logic [31:0]       pc_i,
  input  logic [31:0]       inst_i,
  output logic              reg1_read_o,
  output logic              reg2_read_o,
  output logic [4:0]        reg1_addr_o,
  output logic [4:0]        reg2_addr_o,
  input  logic [DATA_W-1:0] reg1_data_i,
  input  logic [DATA_W-1:0] reg2_data_i,
  input  logic              ex_wreg_i,
  input  logic [4:0]        ex_wd_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  input  logic              ex_is_load_i,
  input  logic              mem_wreg_i,
  input  logic [4:0]        mem_wd_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  input  logic              ex_ready_i,
  output logic              id_valid_o,
  output logic [31:0]       pc_o,
  output logic [7:0]        aluop_o,
  output logic [2:0]        alusel_o,
  output logic [DATA_W-1:0] reg1_o,
  output logic [DATA_W-1:0] reg2_o,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic              instvalid_o
);

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;

  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;

  localparam logic [7:0] ALU_NOP = 8'h00;
  localparam logic [7:0] ALU_SRL = 8'h02;
  localparam logic [7:0] ALU_SRA = 8'h03;
  localparam logic [7:0] ALU_AND = 8'h24;
  localparam logic [7:0] ALU_OR  = 8'h25;
  localparam logic [7:0] ALU_XOR = 8'h26;
  localparam logic [7:0] ALU_NOR = 8'h27;
  localparam logic [7:0] ALU_SLL = 8'h7C;

  localparam logic [2:0] SEL_NOP   = 3'b000;
  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;

  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd, sa;

  assign op    = inst_i[31:26];
  assign rs    = inst_i[25:21];
  assign rt    = inst_i[20:16];
  assign rd    = inst_i[15:11];
  assign sa    = inst_i[10:6];
  assign funct = inst_i[5:0];

  logic              dec_read1, dec_read2, dec_wreg, dec_instvalid;
  logic [7:0]        dec_aluop;
  logic [2:0]        dec_alusel;
  logic [4:0]        dec_wd;
  logic [DATA_W-1:0] dec_imm1, dec_imm2;

  always_comb begin
    dec_read1     = 1'b0;
    dec_read2     = 1'b0;
    dec_wreg      = 1'b0;
    dec_instvalid = 1'b0;
    dec_aluop     = ALU_NOP;
    dec_alusel    = SEL_NOP;
    dec_wd        = 5'd0;
    dec_imm1      = '0;
    dec_imm2      = '0;
    case (op)
      OP_ORI, OP_ANDI, OP_XORI: begin
        dec_read1      = 1'b1;
        dec_imm2[15:0] = inst_i[15:0];
        dec_wd         = rt;
        dec_wreg       = 1'b1;
        dec_instvalid  = 1'b1;
        dec_alusel     = SEL_LOGIC;
        case (op)
          OP_ANDI: dec_aluop = ALU_AND;
          OP_XORI: dec_aluop = ALU_XOR;
          default: dec_aluop = ALU_OR;
        endcase
      end
      OP_LUI: begin
        // Upper-immediate load is an OR of the shifted immediate with zero.
        dec_imm2[31:16] = inst_i[15:0];
        dec_wd          = rt;
        dec_wreg        = 1'b1;
        dec_instvalid   = 1'b1;
        dec_alusel      = SEL_LOGIC;
        dec_aluop       = ALU_OR;
      end
      OP_SPECIAL: begin
        if ((sa == 5'd0) && (funct inside {FN_AND, FN_OR, FN_XOR, FN_NOR})) begin
          dec_read1     = 1'b1;
          dec_read2     = 1'b1;
          dec_wd        = rd;
          dec_wreg      = 1'b1;
          dec_instvalid = 1'b1;
          dec_alusel    = SEL_LOGIC;
          case (funct)
            FN_AND:  dec_aluop = ALU_AND;
            FN_OR:   dec_aluop = ALU_OR;
            FN_XOR:  dec_aluop = ALU_XOR;
            default: dec_aluop = ALU_NOR;
          endcase
        end else if ((rs == 5'd0) && (funct inside {FN_SLL, FN_SRL, FN_SRA})) begin
          dec_read2      = 1'b1;
          dec_imm1[4:0]  = sa;
          dec_wd         = rd;
          dec_wreg       = 1'b1;
          dec_instvalid  = 1'b1;
          dec_alusel     = SEL_SHIFT;
          case (funct)
            FN_SRL:  dec_aluop = ALU_SRL;
            FN_SRA:  dec_aluop = ALU_SRA;
            default: dec_aluop = ALU_SLL;
          endcase
        end
      end
      default: ;
    endcase
  end

  // $0 always reads as zero, whatever a later stage claims to be writing.
  function automatic logic [DATA_W-1:0] src_value(input logic [4:0] addr,
                                                  input logic [DATA_W-1:0] rf_data);
    if (addr == 5'd0) return '0;
`ifdef ID_PIPE_FWD_EN
    if (ex_wreg_i && !ex_is_load_i && (ex_wd_i == addr)) return ex_wdata_i;
    if (mem_wreg_i && (mem_wd_i == addr)) return mem_wdata_i;
`endif
    return rf_data;
  endfunction

  function automatic logic src_hazard(input logic live, input logic [4:0] addr);
    logic hit;
    hit = live & ex_wreg_i & ex_is_load_i & (ex_wd_i == addr);
`ifndef ID_PIPE_FWD_EN
    hit = hit | (live & ex_wreg_i & (ex_wd_i == addr))
              | (live & mem_wreg_i & (mem_wd_i == addr));
`endif
    return hit;
  endfunction

`ifndef ID_PIPE_FWD_EN
  logic unused_fwd_data;
  assign unused_fwd_data = ^{ex_wdata_i, mem_wdata_i};
`endif

  logic              live1, live2, hazard, advance;
  logic [DATA_W-1:0] op1, op2;

  assign live1   = dec_read1 & (rs != 5'd0);
  assign live2   = dec_read2 & (rt != 5'd0);
  assign hazard  = src_hazard(live1, rs) | src_hazard(live2, rt);
  assign op1     = dec_read1 ? src_value(rs, reg1_data_i) : dec_imm1;
  assign op2     = dec_read2 ? src_value(rt, reg2_data_i) : dec_imm2;

  logic              id_valid_q, id_valid_d;
  logic [31:0]       pc_q, pc_d;
  logic [7:0]        aluop_q, aluop_d;
  logic [2:0]        alusel_q, alusel_d;
  logic [DATA_W-1:0] reg1_q, reg1_d, reg2_q, reg2_d;
  logic [4:0]        wd_q, wd_d;
  logic              wreg_q, wreg_d, instvalid_q, instvalid_d;

  assign advance     = ~id_valid_q | ex_ready_i;
  assign if_ready_o  = ~rst & advance & ~hazard;
  assign reg1_read_o = ~rst & dec_read1;
  assign reg2_read_o = ~rst & dec_read2;
  assign reg1_addr_o = rst ? 5'd0 : rs;
  assign reg2_addr_o = rst ? 5'd0 : rt;

  always_comb begin
    id_valid_d  = id_valid_q;
    pc_d        = pc_q;
    aluop_d     = aluop_q;
    alusel_d    = alusel_q;
    reg1_d      = reg1_q;
    reg2_d      = reg2_q;
    wd_d        = wd_q;
    wreg_d      = wreg_q;
    instvalid_d = instvalid_q;
    if (advance) begin
      id_valid_d  = 1'b0;
      pc_d        = '0;
      aluop_d     = ALU_NOP;
      alusel_d    = SEL_NOP;
      reg1_d      = '0;
      reg2_d      = '0;
      wd_d        = 5'd0;
      wreg_d      = 1'b0;
      instvalid_d = 1'b0;
      if (if_valid_i && !hazard) begin
        id_valid_d  = 1'b1;
        pc_d        = pc_i;
        aluop_d     = dec_aluop;
        alusel_d    = dec_alusel;
        reg1_d      = op1;
        reg2_d      = op2;
        wd_d        = dec_wd;
        wreg_d      = dec_wreg;
        instvalid_d = dec_instvalid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid_q  <= 1'b0;
      pc_q        <= '0;
      aluop_q     <= ALU_NOP;
      alusel_q    <= SEL_NOP;
      reg1_q      <= '0;
      reg2_q      <= '0;
      wd_q        <= 5'd0;
      wreg_q      <= 1'b0;
      instvalid_q <= 1'b0;
    end else begin
      id_valid_q  <= id_valid_d;
      pc_q        <= pc_d;
      aluop_q     <= aluop_d;
      alusel_q    <= alusel_d;
      reg1_q      <= reg1_d;
      reg2_q      <= reg2_d;
      wd_q        <= wd_d;
      wreg_q      <= wreg_d;
      instvalid_q <= instvalid_d;
    end
  end

  assign id_valid_o  = id_valid_q;
  assign pc_o        = pc_q;
  assign aluop_o     = aluop_q;
  assign alusel_o    = alusel_q;
  assign reg1_o      = reg1_q;
  assign reg2_o      = reg2_q;
  assign wd_o        = wd_q;
  assign wreg_o      = wreg_q;
  assign instvalid_o = instvalid_q;

endmodule
`default_nettype wire

// File: tb/tb_id_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_pipe -- decode vectors, stall/backpressure/reset sequences, random traffic vs model.
// Revision : 1.0
// ============================================================================
module tb_id_pipe;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, if_valid, ex_ready, ex_wreg, ex_is_load, mem_wreg;
  logic [31:0] pc, inst, ex_wdata, mem_wdata;
  logic [4:0]  ex_wd, mem_wd;
  logic [31:0] rf [32];

  logic        if_ready_o, reg1_read_o, reg2_read_o, id_valid_o, wreg_o, instvalid_o;
  logic [4:0]  reg1_addr_o, reg2_addr_o, wd_o;
  logic [31:0] pc_o, reg1_o, reg2_o, reg1_data, reg2_data;
  logic [7:0]  aluop_o;
  logic [2:0]  alusel_o;

  assign reg1_data = rf[reg1_addr_o];
  assign reg2_data = rf[reg2_addr_o];

  id_pipe #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .if_valid_i(if_valid), .if_ready_o(if_ready_o),
    .pc_i(pc), .inst_i(inst),
    .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o),
    .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
    .reg1_data_i(reg1_data), .reg2_data_i(reg2_data),
    .ex_wreg_i(ex_wreg), .ex_wd_i(ex_wd), .ex_wdata_i(ex_wdata), .ex_is_load_i(ex_is_load),
    .mem_wreg_i(mem_wreg), .mem_wd_i(mem_wd), .mem_wdata_i(mem_wdata),
    .ex_ready_i(ex_ready),
    .id_valid_o(id_valid_o), .pc_o(pc_o), .aluop_o(aluop_o), .alusel_o(alusel_o),
    .reg1_o(reg1_o), .reg2_o(reg2_o), .wd_o(wd_o), .wreg_o(wreg_o), .instvalid_o(instvalid_o)
  );

  int total = 0;
  int bad   = 0;
  logic last_ready;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        ok;
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic        rd1, rd2;
    logic [31:0] imm1, imm2;
    logic [4:0]  wd;
    logic        wreg;
  } dec_t;

  function automatic dec_t model_decode(input logic [31:0] w);
    dec_t d;
    logic [5:0] opc, fn;
    opc = w[31:26];
    fn  = w[5:0];
    d   = '0;
    if (opc inside {6'h0c, 6'h0d, 6'h0e}) begin
      d.ok = 1; d.rd1 = 1; d.alusel = 3'd1; d.wreg = 1; d.wd = w[20:16];
      d.aluop = 8'h24 + 8'(opc - 6'h0c);
      d.imm2  = {16'h0, w[15:0]};
    end else if (opc == 6'h0f) begin
      d.ok = 1; d.alusel = 3'd1; d.wreg = 1; d.wd = w[20:16];
      d.aluop = 8'h25;
      d.imm2  = {w[15:0], 16'h0};
    end else if (opc == 6'h00 && w[10:6] == 0 && fn[5:2] == 4'b1001) begin
      d.ok = 1; d.rd1 = 1; d.rd2 = 1; d.alusel = 3'd1; d.wreg = 1; d.wd = w[15:11];
      d.aluop = 8'h24 + 8'(fn[1:0]);
    end else if (opc == 6'h00 && w[25:21] == 0 && fn inside {6'd0, 6'd2, 6'd3}) begin
      d.ok = 1; d.rd2 = 1; d.alusel = 3'd2; d.wreg = 1; d.wd = w[15:11];
      d.aluop = (fn == 0) ? 8'h7C : 8'(fn);
      d.imm1  = 32'(w[10:6]);
    end
    return d;
  endfunction

  function automatic logic [31:0] model_src(input logic [4:0] r);
    if (r == 0) return 32'h0;
`ifdef ID_PIPE_FWD_EN
    if (ex_wreg && !ex_is_load && ex_wd == r) return ex_wdata;
    if (mem_wreg && mem_wd == r) return mem_wdata;
`endif
    return rf[r];
  endfunction

  function automatic logic model_hazard(input dec_t d, input logic [31:0] w);
    logic [4:0] srcs[$];
    logic h;
    h = 0;
    if (d.rd1 && w[25:21] != 0) srcs.push_back(w[25:21]);
    if (d.rd2 && w[20:16] != 0) srcs.push_back(w[20:16]);
    foreach (srcs[i]) begin
      if (ex_wreg && ex_is_load && ex_wd == srcs[i]) h = 1;
`ifndef ID_PIPE_FWD_EN
      if ((ex_wreg && ex_wd == srcs[i]) || (mem_wreg && mem_wd == srcs[i])) h = 1;
`endif
    end
    return h;
  endfunction

  logic        m_valid = 0, m_wreg = 0, m_instvalid = 0, m_after_rst = 0;
  logic [31:0] m_pc = 0, m_reg1 = 0, m_reg2 = 0;
  logic [7:0]  m_aluop = 0;
  logic [2:0]  m_alusel = 0;
  logic [4:0]  m_wd = 0;

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic step();
    dec_t d;
    logic haz, adv;
    #1;
    d   = model_decode(inst);
    haz = model_hazard(d, inst);
    adv = !m_valid || ex_ready;
    last_ready = if_ready_o;
    check("if_ready",  if_ready_o,  !rst && adv && !haz);
    check("reg1_read", reg1_read_o, !rst && d.rd1);
    check("reg2_read", reg2_read_o, !rst && d.rd2);
    check("reg1_addr", reg1_addr_o, rst ? 5'd0 : inst[25:21]);
    check("reg2_addr", reg2_addr_o, rst ? 5'd0 : inst[20:16]);
    if (rst) begin
      {m_valid, m_wreg, m_instvalid, m_pc, m_reg1, m_reg2, m_aluop, m_alusel, m_wd} = '0;
      m_after_rst = 1;
    end else if (adv) begin
      m_after_rst = 0;
      if (if_valid && !haz) begin
        m_valid = 1; m_pc = pc; m_aluop = d.aluop; m_alusel = d.alusel;
        m_wd = d.wd; m_wreg = d.wreg; m_instvalid = d.ok;
        m_reg1 = d.rd1 ? model_src(inst[25:21]) : d.imm1;
        m_reg2 = d.rd2 ? model_src(inst[20:16]) : d.imm2;
      end else begin
        m_valid = 0; m_aluop = 0; m_alusel = 0; m_wreg = 0; m_instvalid = 0;
      end
    end
    @(posedge clk);
    #1;
    check("id_valid",  id_valid_o,  m_valid);
    check("aluop",     aluop_o,     m_aluop);
    check("alusel",    alusel_o,    m_alusel);
    check("wreg",      wreg_o,      m_wreg);
    check("instvalid", instvalid_o, m_instvalid);
    if (m_valid || m_after_rst) check("pc", pc_o, m_pc);
    if ((m_valid && m_instvalid) || m_after_rst) begin
      check("reg1", reg1_o, m_reg1);
      check("reg2", reg2_o, m_reg2);
      check("wd",   wd_o,   m_wd);
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    w = $urandom;
    w[25:21] = 5'($urandom_range(0, 3));
    w[20:16] = 5'($urandom_range(0, 3));
    case ($urandom_range(0, 3))
      0: w[31:26] = 6'h0c + 6'($urandom_range(0, 3));
      1: begin
        w[31:26] = 0;
        w[10:6]  = ($urandom_range(0, 7) == 0) ? 5'd1 : 5'd0;
        w[5:0]   = {4'b1001, 2'($urandom_range(0, 3))};
      end
      2: begin
        w[31:26] = 0;
        if ($urandom_range(0, 7) != 0) w[25:21] = 0;
        w[5:0] = 6'($urandom_range(0, 3));
      end
      default: w[31:26] = 6'($urandom);
    endcase
    return w;
  endfunction

  typedef struct {
    logic [31:0] inst;
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [4:0]  wd;
    logic        wreg;
    logic        instvalid;
    logic        chk_ops;
    logic [31:0] reg1;
    logic [31:0] reg2;
  } vec_t;

  vec_t vecs [15];

  task automatic clear_fwd();
    ex_wreg = 0; ex_is_load = 0; ex_wd = 0; ex_wdata = 0;
    mem_wreg = 0; mem_wd = 0; mem_wdata = 0;
  endtask

  initial begin
    vecs[0]  = '{32'h34011100, 8'h25, 3'd1, 5'd1, 1, 1, 1, 32'h0,        32'h00001100};
    vecs[1]  = '{32'h3022FFFF, 8'h24, 3'd1, 5'd2, 1, 1, 1, 32'h11110001, 32'h0000FFFF};
    vecs[2]  = '{32'h38438000, 8'h26, 3'd1, 5'd3, 1, 1, 1, 32'h11110002, 32'h00008000};
    vecs[3]  = '{32'h3C04ABCD, 8'h25, 3'd1, 5'd4, 1, 1, 1, 32'h0,        32'hABCD0000};
    vecs[4]  = '{32'h00221825, 8'h25, 3'd1, 5'd3, 1, 1, 1, 32'h11110001, 32'h11110002};
    vecs[5]  = '{32'h00C72824, 8'h24, 3'd1, 5'd5, 1, 1, 1, 32'h11110006, 32'h11110007};
    vecs[6]  = '{32'h012A4027, 8'h27, 3'd1, 5'd8, 1, 1, 1, 32'h11110009, 32'h1111000A};
    vecs[7]  = '{32'h00221826, 8'h26, 3'd1, 5'd3, 1, 1, 1, 32'h11110001, 32'h11110002};
    vecs[8]  = '{32'h00031100, 8'h7C, 3'd2, 5'd2, 1, 1, 1, 32'h4,        32'h11110003};
    vecs[9]  = '{32'h000317C2, 8'h02, 3'd2, 5'd2, 1, 1, 1, 32'h1F,       32'h11110003};
    vecs[10] = '{32'h00031043, 8'h03, 3'd2, 5'd2, 1, 1, 1, 32'h1,        32'h11110003};
    vecs[11] = '{32'h00000000, 8'h7C, 3'd2, 5'd0, 1, 1, 1, 32'h0,        32'h0};
    vecs[12] = '{32'hFC000000, 8'h00, 3'd0, 5'd0, 0, 0, 0, 32'h0,        32'h0};
    vecs[13] = '{32'h00611000, 8'h00, 3'd0, 5'd0, 0, 0, 0, 32'h0,        32'h0};
    vecs[14] = '{32'h00221865, 8'h00, 3'd0, 5'd0, 0, 0, 0, 32'h0,        32'h0};

    for (int i = 0; i < 32; i++) rf[i] = 32'h11110000 | 32'(i);
    rf[0] = 32'hDEADBEEF;
    rst = 1; if_valid = 1; ex_ready = 1; pc = 32'h100; inst = 32'h34011100;
    clear_fwd();

    // Reset: an instruction presented during reset is dropped.
    @(negedge clk);
    step();
    step();
    check("rst_id_valid", id_valid_o, 0);
    check("rst_reg2", reg2_o, 0);
    rst = 0; if_valid = 0;
    step();
    check("drop_in_rst", id_valid_o, 0);

    // ORI $1,$0,0x1100 after reset.
    if_valid = 1; pc = 32'h400; inst = 32'h34011100;
    step();
    check("ori_valid", id_valid_o, 1);
    check("ori_aluop", aluop_o, 8'h25);
    check("ori_reg2", reg2_o, 32'h00001100);

    // Decode table, back to back.
    for (int i = 0; i < 15; i++) begin
      inst = vecs[i].inst; pc = 32'h1000 + 32'(4 * i);
      step();
      check("tbl_id_valid",  id_valid_o,  1);
      check("tbl_pc",        pc_o,        32'h1000 + 32'(4 * i));
      check("tbl_aluop",     aluop_o,     vecs[i].aluop);
      check("tbl_alusel",    alusel_o,    vecs[i].alusel);
      check("tbl_wreg",      wreg_o,      vecs[i].wreg);
      check("tbl_instvalid", instvalid_o, vecs[i].instvalid);
      if (vecs[i].chk_ops) begin
        check("tbl_wd",   wd_o,   vecs[i].wd);
        check("tbl_reg1", reg1_o, vecs[i].reg1);
        check("tbl_reg2", reg2_o, vecs[i].reg2);
      end
    end

    // OR $3,$1,$2 while EX and MEM both target $1.
    inst = 32'h00221825; pc = 32'h2000;
    ex_wreg = 1; ex_wd = 1; ex_wdata = 32'hA5A5A5A5;
    mem_wreg = 1; mem_wd = 1; mem_wdata = 32'h1;
`ifdef ID_PIPE_FWD_EN
    step();
    check("fwd_ex_prio", reg1_o, 32'hA5A5A5A5);
    check("fwd_valid", id_valid_o, 1);
`else
    for (int i = 0; i < 2; i++) begin
      step();
      check("raw_ready", last_ready, 0);
      check("raw_bubble", id_valid_o, 0);
    end
    clear_fwd();
    step();
    check("raw_release", id_valid_o, 1);
    check("raw_reg1", reg1_o, 32'h11110001);
`endif

    // Load-use: EX loads $2, AND $4,$2,$5 waits one cycle.
    clear_fwd();
    ex_wreg = 1; ex_wd = 2; ex_is_load = 1;
    inst = 32'h00452024; pc = 32'h3000;
    step();
    check("lu_ready", last_ready, 0);
    check("lu_bubble", id_valid_o, 0);
    clear_fwd();
    step();
    check("lu_accept", id_valid_o, 1);
    check("lu_reg1", reg1_o, 32'h11110002);
    check("lu_wd", wd_o, 5'd4);

    // Backpressure for three cycles.
    inst = 32'h38438000; pc = 32'h500;
    step();
    ex_ready = 0; inst = 32'h34011100; pc = 32'h504;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_ready", last_ready, 0);
      check("bp_pc_hold", pc_o, 32'h500);
      check("bp_aluop_hold", aluop_o, 8'h26);
    end
    ex_ready = 1;
    step();
    check("bp_next_pc", pc_o, 32'h504);
    if_valid = 0;
    step();
    check("bp_no_dup", id_valid_o, 0);

    // Stall and backpressure together, then reset mid-stall.
    if_valid = 1; inst = 32'h34011100; pc = 32'h600;
    step();
    ex_ready = 0; ex_wreg = 1; ex_wd = 2; ex_is_load = 1;
    inst = 32'h00452024; pc = 32'h604;
    step();
    check("sb_ready", last_ready, 0);
    check("sb_hold_pc", pc_o, 32'h600);
    rst = 1;
    step();
    check("rst_stall_valid", id_valid_o, 0);
    check("rst_stall_pc", pc_o, 0);
    check("rst_stall_reg2", reg2_o, 0);
    check("rst_stall_wreg", wreg_o, 0);
    rst = 0; clear_fwd(); ex_ready = 1; inst = 32'h34011100; pc = 32'h700;
    step();
    check("post_rst_ready", last_ready, 1);
    check("post_rst_pc", pc_o, 32'h700);

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      rst        = ($urandom_range(0, 63) == 0);
      if_valid   = ($urandom_range(0, 3) != 0);
      ex_ready   = ($urandom_range(0, 3) != 0);
      inst       = rand_inst();
      pc         = $urandom;
      ex_wreg    = 1'($urandom_range(0, 1));
      ex_wd      = 5'($urandom_range(0, 3));
      ex_is_load = ($urandom_range(0, 3) == 0);
      ex_wdata   = $urandom;
      mem_wreg   = 1'($urandom_range(0, 1));
      mem_wd     = 5'($urandom_range(0, 3));
      mem_wdata  = $urandom;
      if (n % 16 == 0) for (int i = 0; i < 32; i++) rf[i] = $urandom;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
